// File: rtl/user_bitrev_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// user_bitrev_ctrl
//
// OBI subordinate that owns a small buffer of 32-bit words and streams them,
// one at a time, through an external bit-reversal datapath. Each result is
// written back in place. Software fills the buffer, programs LEN and writes
// START; when the run ends DONE is set and, if enabled, irq_o is raised.
//
// Register map (byte offsets, addr[7:2] decoded):
//   0x00 CTRL    W   bit0 START, bit1 CLEAR_DONE, bit2 ABORT (reads 0)
//   0x04 STATUS  R   bit0 BUSY, bit1 DONE, bit2 ABORTED, bits[12:8] idx
//   0x08 LEN     RW  5 bits, writes clamp to Depth
//   0x0C IRQ_EN  RW  bit0
//   0x40+4*i     RW  buffer word i (i < Depth), byte enables honoured
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   obi_*                OBI subordinate port (always granted, 1-cycle response)
//   dp_req_valid_o/ready_i/data_o   word handed to the datapath
//   dp_rsp_valid_i/data_i           result coming back from the datapath
//   irq_o                level interrupt, DONE & IRQ_EN
// -----------------------------------------------------------------------------
module user_bitrev_ctrl #(
   parameter int unsigned Depth   = 16,
   parameter int unsigned IdWidth = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   // OBI subordinate
   input  logic               obi_req_i,
   output logic               obi_gnt_o,
   input  logic [31:0]        obi_addr_i,
   input  logic               obi_we_i,
   input  logic [3:0]         obi_be_i,
   input  logic [31:0]        obi_wdata_i,
   input  logic [IdWidth-1:0] obi_aid_i,
   output logic               obi_rvalid_o,
   output logic [31:0]        obi_rdata_o,
   output logic [IdWidth-1:0] obi_rid_o,
   output logic               obi_err_o,
   // datapath
   output logic               dp_req_valid_o,
   input  logic               dp_req_ready_i,
   output logic [31:0]        dp_req_data_o,
   input  logic               dp_rsp_valid_i,
   input  logic [31:0]        dp_rsp_data_i,
   // interrupt
   output logic               irq_o
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   // LEN never exceeds the buffer depth, so the run cannot index past it.
   function automatic logic [4:0] clamp_len(input logic [4:0] v);
      if (32'(v) > Depth) begin
         return 5'(Depth);
      end
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              r_state;
   state_t              w_state_nxt;

   logic [4:0]          r_len;
   logic                r_irq_en;
   logic                r_done;
   logic                r_aborted;
   logic                r_abort_pend;
   logic [4:0]          r_idx;

   logic [DATA_W-1:0]   r_buf [Depth];

   logic                r_rvalid;
   logic [DATA_W-1:0]   r_rdata;
   logic [IdWidth-1:0]  r_rid;
   logic                r_err;

   // ---------------------------------------------------------------------------
   // OBI decode
   // ---------------------------------------------------------------------------
   logic [5:0]          w_off;
   logic [3:0]          w_buf_idx;
   logic                w_is_ctrl;
   logic                w_is_status;
   logic                w_is_len;
   logic                w_is_irqen;
   logic                w_is_buf;
   logic                w_busy;
   logic [DATA_W-1:0]   w_status;

   logic                w_err;
   logic [DATA_W-1:0]   w_rdata;
   logic                w_start;
   logic                w_clr_done;
   logic                w_abort;
   logic                w_len_we;
   logic                w_irqen_we;
   logic                w_buf_we;
   logic                w_dp_wb;
   logic                w_last;
   logic                w_unused;

   assign w_off       = obi_addr_i[7:2];
   assign w_buf_idx   = w_off[3:0];
   assign w_is_ctrl   = (w_off == 6'd0);
   assign w_is_status = (w_off == 6'd1);
   assign w_is_len    = (w_off == 6'd2);
   assign w_is_irqen  = (w_off == 6'd3);
   // Buffer window starts at word offset 16 (byte 0x40).
   assign w_is_buf    = (w_off[5:4] == 2'b01) && (32'(w_buf_idx) < Depth);
   assign w_busy      = (r_state != S_IDLE);
   assign w_status    = {19'd0, r_idx, 5'd0, r_aborted, r_done, w_busy};
   assign w_unused    = ^{obi_addr_i[31:8], obi_addr_i[1:0]};

   always_comb begin
      w_err      = 1'b0;
      w_rdata    = '0;
      w_start    = 1'b0;
      w_clr_done = 1'b0;
      w_abort    = 1'b0;
      w_len_we   = 1'b0;
      w_irqen_we = 1'b0;
      w_buf_we   = 1'b0;
      if (obi_req_i) begin
         if (w_is_ctrl) begin
            if (obi_we_i) begin
               // A START while running rejects the whole write, abort included.
               if (obi_wdata_i[0] && w_busy) begin
                  w_err = 1'b1;
               end else begin
                  w_start    = obi_wdata_i[0];
                  w_clr_done = obi_wdata_i[1] && !w_busy;
                  w_abort    = obi_wdata_i[2] && w_busy;
               end
            end
         end else if (w_is_status) begin
            if (obi_we_i) begin
               w_err = 1'b1;
            end else begin
               w_rdata = w_status;
            end
         end else if (w_is_len) begin
            if (obi_we_i) begin
               if (w_busy) begin
                  w_err = 1'b1;
               end else begin
                  w_len_we = 1'b1;
               end
            end else begin
               w_rdata = {27'd0, r_len};
            end
         end else if (w_is_irqen) begin
            if (obi_we_i) begin
               w_irqen_we = 1'b1;
            end else begin
               w_rdata = {31'd0, r_irq_en};
            end
         end else if (w_is_buf) begin
            if (obi_we_i) begin
               if (w_busy) begin
                  w_err = 1'b1;
               end else begin
                  w_buf_we = 1'b1;
               end
            end else begin
               w_rdata = r_buf[w_buf_idx];
            end
         end else begin
            w_err = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // OBI response: always granted, answered on the following cycle
   // ---------------------------------------------------------------------------
   assign obi_gnt_o = obi_req_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rid    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_rvalid <= obi_req_i;
         r_rdata  <= (obi_req_i && !w_err) ? w_rdata : '0;
         r_err    <= obi_req_i && w_err;
         if (obi_req_i) begin
            r_rid <= obi_aid_i;
         end
      end
   end

   assign obi_rvalid_o = r_rvalid;
   assign obi_rdata_o  = r_rdata;
   assign obi_rid_o    = r_rid;
   assign obi_err_o    = r_err;

   // ---------------------------------------------------------------------------
   // Sequencer FSM
   // ---------------------------------------------------------------------------
   assign w_dp_wb = (r_state == S_WAIT) && dp_rsp_valid_i;
   // idx still holds the word just completed, so +1 is the processed count.
   assign w_last  = ((r_idx + 5'd1) == r_len) || r_abort_pend || w_abort;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_start && (r_len != 5'd0)) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (dp_req_ready_i) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (dp_rsp_valid_i) begin
               w_state_nxt = w_last ? S_FIN : S_ISSUE;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      dp_req_valid_o = (r_state == S_ISSUE);
      // Buffer writes are blocked while busy, so this stays stable until ready.
      dp_req_data_o  = dp_req_valid_o ? r_buf[r_idx[3:0]] : '0;
   end

   // ---------------------------------------------------------------------------
   // Control / status registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_len        <= 5'd0;
         r_irq_en     <= 1'b0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
         r_abort_pend <= 1'b0;
         r_idx        <= 5'd0;
      end else begin
         if (w_len_we) begin
            r_len <= clamp_len(obi_wdata_i[4:0]);
         end
         if (w_irqen_we) begin
            r_irq_en <= obi_wdata_i[0];
         end
         // START beats CLEAR_DONE; an empty run completes immediately.
         if (w_start) begin
            r_done       <= (r_len == 5'd0);
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_idx        <= 5'd0;
         end else if (w_clr_done) begin
            r_done <= 1'b0;
         end
         if (w_abort) begin
            r_abort_pend <= 1'b1;
         end
         if (w_dp_wb) begin
            r_idx <= r_idx + 5'd1;
         end
         if (r_state == S_FIN) begin
            r_done       <= 1'b1;
            r_aborted    <= r_abort_pend || w_abort;
            r_abort_pend <= 1'b0;
         end
      end
   end

   assign irq_o = r_done && r_irq_en;

   // ---------------------------------------------------------------------------
   // Buffer storage (not reset). OBI writes and datapath writeback are
   // mutually exclusive because OBI buffer writes are rejected while busy.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (w_buf_we) begin
         for (int b = 0; b < 4; b++) begin
            if (obi_be_i[b]) begin
               r_buf[w_buf_idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
            end
         end
      end else if (w_dp_wb) begin
         r_buf[r_idx[3:0]] <= dp_rsp_data_i;
      end
   end

endmodule

// File: tb/tb_user_bitrev_ctrl.sv
`timescale 1ns/1ps
module tb_user_bitrev_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, gnt, we, rvalid, err;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic [0:0]  aid, rid;
   logic        dp_valid, dp_ready, dp_rsp_valid;
   logic [31:0] dp_data, dp_rsp_data;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   user_bitrev_ctrl #(.Depth(16), .IdWidth(1)) dut (
      .clk_i(clk), .rst_i(rst),
      .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_we_i(we),
      .obi_be_i(be), .obi_wdata_i(wdata), .obi_aid_i(aid),
      .obi_rvalid_o(rvalid), .obi_rdata_o(rdata), .obi_rid_o(rid), .obi_err_o(err),
      .dp_req_valid_o(dp_valid), .dp_req_ready_i(dp_ready), .dp_req_data_o(dp_data),
      .dp_rsp_valid_i(dp_rsp_valid), .dp_rsp_data_i(dp_rsp_data),
      .irq_o(irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] bitrev(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // Datapath model: 2-cycle latency bit reverser with programmable stall.
   int          stall_cfg = 0;
   int          stall_left;
   int          pend;
   logic [31:0] pend_data;
   int          hs_count  = 0;
   int          valid_cnt = 0;

   initial begin
      dp_ready = 1'b1; dp_rsp_valid = 1'b0; dp_rsp_data = '0;
      pend = 0; stall_left = 0; pend_data = '0;
      forever begin
         @(negedge clk);
         dp_rsp_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               dp_rsp_valid = 1'b1;
               dp_rsp_data  = bitrev(pend_data);
            end
         end
         if (dp_valid) begin
            valid_cnt++;
            if (stall_left > 0) begin dp_ready = 1'b0; stall_left--; end
            else dp_ready = 1'b1;
         end else begin
            dp_ready   = 1'b1;
            stall_left = stall_cfg;
         end
         if (dp_valid && dp_ready) begin
            hs_count++;
            pend_data = dp_data;
            pend      = 2;
         end
      end
   end

   logic [0:0] aid_next = 1'b0;

   task automatic xfer(input logic w, input logic [7:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
      logic [0:0] sent;
      @(negedge clk);
      req = 1'b1; we = w; addr = {24'd0, a}; be = b; wdata = d; aid = aid_next;
      sent = aid_next;
      #1;
      chk("gnt", 32'(gnt), 32'd1);
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rid", 32'(rid), 32'(sent));
      rd = rdata; er = err;
      aid_next = ~aid_next;
   endtask

   task automatic tx(input string name, input logic w, input logic [7:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd; logic er;
      xfer(w, a, b, d, rd, er);
      chk({name, ".rdata"}, rd, exp_rd);
      chk({name, ".err"}, 32'(er), 32'(exp_er));
   endtask

   task automatic wait_done(input string name);
      logic [31:0] rd; logic er;
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         xfer(1'b0, 8'h04, 4'hF, 32'd0, rd, er);
         if (rd[1]) begin ok = 1'b1; break; end
      end
      chk({name, ".done_timeout"}, 32'(ok), 32'd1);
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [7:0]  addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   function automatic vec_t mk(string n, logic w, logic [7:0] a, logic [3:0] b,
                               logic [31:0] d, logic [31:0] r, logic e);
      vec_t v;
      v.name = n; v.we = w; v.addr = a; v.be = b; v.wd = d; v.rd = r; v.err = e;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[$];
      int          h0;
      bit          seen;
      tbl.push_back(mk("rd_ctrl",    0, 8'h00, 4'hF, 0,            0,            0));
      tbl.push_back(mk("rd_status",  0, 8'h04, 4'hF, 0,            0,            0));
      tbl.push_back(mk("rd_len",     0, 8'h08, 4'hF, 0,            0,            0));
      tbl.push_back(mk("rd_irqen",   0, 8'h0C, 4'hF, 0,            0,            0));
      tbl.push_back(mk("wr_len_1f",  1, 8'h08, 4'hF, 32'h1F,       0,            0));
      tbl.push_back(mk("rd_len_clp", 0, 8'h08, 4'hF, 0,            32'd16,       0));
      tbl.push_back(mk("wr_len_3",   1, 8'h08, 4'hF, 32'h3,        0,            0));
      tbl.push_back(mk("rd_len_3",   0, 8'h08, 4'hF, 0,            32'd3,        0));
      tbl.push_back(mk("wr_status",  1, 8'h04, 4'hF, 32'h1,        0,            1));
      tbl.push_back(mk("rd_st_idle", 0, 8'h04, 4'hF, 0,            0,            0));
      tbl.push_back(mk("rd_0x20",    0, 8'h20, 4'hF, 0,            0,            1));
      tbl.push_back(mk("wr_0x20",    1, 8'h20, 4'hF, 32'h55,       0,            1));
      tbl.push_back(mk("rd_0x80",    0, 8'h80, 4'hF, 0,            0,            1));
      tbl.push_back(mk("wr_buf5",    1, 8'h54, 4'hF, 32'hAABBCCDD, 0,            0));
      tbl.push_back(mk("wr_buf5_b1", 1, 8'h54, 4'h2, 32'h11223344, 0,            0));
      tbl.push_back(mk("rd_buf5",    0, 8'h54, 4'hF, 0,            32'hAABB33DD, 0));
      tbl.push_back(mk("wr_irqen",   1, 8'h0C, 4'hF, 32'hFFFFFFFF, 0,            0));
      tbl.push_back(mk("rd_irqen1",  0, 8'h0C, 4'hF, 0,            32'd1,        0));
      tbl.push_back(mk("wr_irqen0",  1, 8'h0C, 4'hF, 32'h0,        0,            0));
      tbl.push_back(mk("wr_buf0",    1, 8'h40, 4'hF, 32'h00000001, 0,            0));
      tbl.push_back(mk("wr_buf1",    1, 8'h44, 4'hF, 32'h0000000F, 0,            0));
      tbl.push_back(mk("wr_buf2",    1, 8'h48, 4'hF, 32'h12345678, 0,            0));

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; aid = '0;
      repeat (3) @(negedge clk);
      chk("rst.rvalid", 32'(rvalid), 0);
      chk("rst.rdata", rdata, 0);
      chk("rst.err", 32'(err), 0);
      chk("rst.gnt", 32'(gnt), 0);
      chk("rst.dp_valid", 32'(dp_valid), 0);
      chk("rst.dp_data", dp_data, 0);
      chk("rst.irq", 32'(irq), 0);
      rst = 1'b0;

      foreach (tbl[i]) tx(tbl[i].name, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, tbl[i].rd, tbl[i].err);

      // Three-word run
      tx("start3", 1, 8'h00, 4'hF, 32'h1, 0, 0);
      wait_done("run3");
      tx("run3.buf0", 0, 8'h40, 4'hF, 0, 32'h80000000, 0);
      tx("run3.buf1", 0, 8'h44, 4'hF, 0, 32'hF0000000, 0);
      tx("run3.buf2", 0, 8'h48, 4'hF, 0, 32'h1E6A2C48, 0);
      tx("run3.status", 0, 8'h04, 4'hF, 0, 32'h302, 0);

      // Interrupt timing: irq rises the cycle after FIN
      tx("irq.en", 1, 8'h0C, 4'hF, 32'h1, 0, 0);
      tx("irq.len", 1, 8'h08, 4'hF, 32'h1, 0, 0);
      tx("irq.start", 1, 8'h00, 4'hF, 32'h1, 0, 0);
      chk("irq.cleared_by_start", 32'(irq), 0);
      repeat (3) @(posedge clk);
      #1 chk("irq.in_fin", 32'(irq), 0);
      @(posedge clk);
      #1 chk("irq.after_fin", 32'(irq), 1);
      tx("irq.clear", 1, 8'h00, 4'hF, 32'h2, 0, 0);
      chk("irq.cleared", 32'(irq), 0);
      tx("irq.status", 0, 8'h04, 4'hF, 0, 32'h100, 0);

      // Empty run
      tx("len0.len", 1, 8'h08, 4'hF, 32'h0, 0, 0);
      h0 = valid_cnt;
      tx("len0.start", 1, 8'h00, 4'hF, 32'h1, 0, 0);
      chk("len0.irq", 32'(irq), 1);
      tx("len0.status", 0, 8'h04, 4'hF, 0, 32'h2, 0);
      chk("len0.no_dp_valid", 32'(valid_cnt - h0), 0);

      // START together with CLEAR_DONE: DONE drops
      tx("sc.len", 1, 8'h08, 4'hF, 32'h1, 0, 0);
      tx("sc.start_clr", 1, 8'h00, 4'hF, 32'h3, 0, 0);
      chk("sc.irq_low", 32'(irq), 0);
      wait_done("sc");

      // Stalled ISSUE: data stable, writes rejected
      tx("stall.irqen0", 1, 8'h0C, 4'hF, 32'h0, 0, 0);
      tx("stall.buf0", 1, 8'h40, 4'hF, 32'h000000FF, 0, 0);
      tx("stall.buf1", 1, 8'h44, 4'hF, 32'h00000001, 0, 0);
      tx("stall.len", 1, 8'h08, 4'hF, 32'h2, 0, 0);
      stall_cfg = 5;
      tx("stall.start", 1, 8'h00, 4'hF, 32'h1, 0, 0);
      chk("stall.valid0", 32'(dp_valid), 1);
      chk("stall.data0", dp_data, 32'hFF);
      tx("stall.status", 0, 8'h04, 4'hF, 0, 32'h1, 0);
      tx("stall.wr_buf", 1, 8'h40, 4'hF, 32'hDEADBEEF, 0, 1);
      chk("stall.valid1", 32'(dp_valid), 1);
      chk("stall.data1", dp_data, 32'hFF);
      tx("stall.wr_len", 1, 8'h08, 4'hF, 32'h4, 0, 1);
      tx("stall.restart", 1, 8'h00, 4'hF, 32'h1, 0, 1);
      stall_cfg = 0;
      wait_done("stall");
      tx("stall.rb0", 0, 8'h40, 4'hF, 0, 32'hFF000000, 0);
      tx("stall.rb1", 0, 8'h44, 4'hF, 0, 32'h80000000, 0);
      tx("stall.rlen", 0, 8'h08, 4'hF, 0, 32'h2, 0);

      // Abort with idx=2 in WAIT
      tx("abort.buf3", 1, 8'h4C, 4'hF, 32'h3, 0, 0);
      tx("abort.len", 1, 8'h08, 4'hF, 32'h8, 0, 0);
      h0 = hs_count;
      tx("abort.start", 1, 8'h00, 4'hF, 32'h1, 0, 0);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (hs_count - h0 == 3) begin seen = 1'b1; break; end
      end
      chk("abort.reach_word2", 32'(seen), 1);
      tx("abort.cmd", 1, 8'h00, 4'hF, 32'h4, 0, 0);
      wait_done("abort");
      chk("abort.words", 32'(hs_count - h0), 3);
      tx("abort.status", 0, 8'h04, 4'hF, 0, 32'h306, 0);
      tx("abort.buf3", 0, 8'h4C, 4'hF, 0, 32'h3, 0);
      tx("abort.idle_abort", 1, 8'h00, 4'hF, 32'h4, 0, 0);
      tx("abort.status2", 0, 8'h04, 4'hF, 0, 32'h306, 0);

      // Reset while ISSUE is stalled
      stall_cfg = 20;
      tx("rstI.len", 1, 8'h08, 4'hF, 32'h2, 0, 0);
      tx("rstI.start", 1, 8'h00, 4'hF, 32'h1, 0, 0);
      chk("rstI.valid_before", 32'(dp_valid), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstI.valid_after", 32'(dp_valid), 0);
      chk("rstI.rvalid", 32'(rvalid), 0);
      stall_cfg = 0;
      tx("rstI.status", 0, 8'h04, 4'hF, 0, 32'h0, 0);
      tx("rstI.len_rd", 0, 8'h08, 4'hF, 0, 32'h0, 0);

      // Reset while WAIT: late response must be ignored
      tx("rstW.buf0", 1, 8'h40, 4'hF, 32'h1, 0, 0);
      tx("rstW.len", 1, 8'h08, 4'hF, 32'h1, 0, 0);
      h0 = hs_count;
      tx("rstW.start", 1, 8'h00, 4'hF, 32'h1, 0, 0);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (hs_count - h0 == 1) begin seen = 1'b1; break; end
      end
      chk("rstW.handshake", 32'(seen), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      tx("rstW.status", 0, 8'h04, 4'hF, 0, 32'h0, 0);
      tx("rstW.buf0", 0, 8'h40, 4'hF, 0, 32'h1, 0);

      // Back-to-back reads
      tx("b2b.len", 1, 8'h08, 4'hF, 32'h5, 0, 0);
      tx("b2b.irqen", 1, 8'h0C, 4'hF, 32'h1, 0, 0);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h08; aid = 1'b0;
      @(negedge clk);
      chk("b2b.rv0", 32'(rvalid), 1);
      chk("b2b.rd0", rdata, 32'h5);
      chk("b2b.rid0", 32'(rid), 0);
      addr = 32'h0C; aid = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk("b2b.rv1", 32'(rvalid), 1);
      chk("b2b.rd1", rdata, 32'h1);
      chk("b2b.rid1", 32'(rid), 1);
      @(negedge clk);
      chk("b2b.rv_idle", 32'(rvalid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/user_bitrev_ctrl.md
Name: user_bitrev_ctrl

Overview:
- OBI subordinate controller that sequences a shared, external 32-bit bit-reversal datapath over a small word buffer.
- Sits in the user domain behind the user OBI demux as one subordinate port. Its datapath side connects to the bitrev unit.
- Software fills the buffer, programs LEN and writes START. The controller streams each word through the datapath, writes each result back in place, then raises DONE and an optional level interrupt.

Parameters:
- Depth, 16, number of 32-bit buffer words; legal range 1..16.
- IdWidth, 1, OBI aid/rid width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant
- obi_addr_i  in  32  byte address; only bits [7:2] are decoded
- obi_we_i  in  1  write enable
- obi_be_i  in  4  byte enables
- obi_wdata_i  in  32  write data
- obi_aid_i  in  IdWidth  transaction id
- obi_rvalid_o  out  1  response valid
- obi_rdata_o  out  32  read data
- obi_rid_o  out  IdWidth  response id (echoes aid)
- obi_err_o  out  1  response error
- dp_req_valid_o  out  1  word valid to datapath
- dp_req_ready_i  in  1  datapath accepts word
- dp_req_data_o  out  32  word to datapath
- dp_rsp_valid_i  in  1  datapath result valid
- dp_rsp_data_i  in  32  datapath result
- irq_o  out  1  level interrupt

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; LEN=0, IRQ_EN=0, DONE=0, ABORTED=0, idx=0. Buffer contents are not reset.
- OBI timing:
  - obi_gnt_o = obi_req_i (always grant).
  - Response exactly 1 cycle after grant: rvalid=1, with rid, rdata and err registered.
  - Back-to-back requests every cycle are supported.
  - When err=1, rdata=0.
- Register map (offset = addr[7:2]*4):
  - 0x00 CTRL: write-only, reads 0. bit0 START, bit1 CLEAR_DONE, bit2 ABORT.
  - 0x04 STATUS: read-only; writes give err. bit0 BUSY, bit1 DONE, bit2 ABORTED, bits[12:8] idx.
  - 0x08 LEN: RW, 5 bits. A write stores min(wdata[4:0], Depth).
  - 0x0C IRQ_EN: RW, bit0.
  - 0x40 + 4*i, for i < Depth: buffer word i.
    - Reads are always allowed.
    - Writes honour obi_be_i per byte.
  - Any other offset: err=1, no side effect.
- Registers ignore obi_be_i; a full-word write is assumed.
- Writes while BUSY: any LEN or buffer write, or START, gives err=1 and no effect. CLEAR_DONE while busy has no effect and no err. ABORT is accepted.
- FSM IDLE:
  - START (while not busy) clears DONE and ABORTED, sets idx=0.
  - If LEN==0: DONE=1 next cycle, no datapath traffic, stay IDLE.
  - Otherwise go to ISSUE.
- FSM ISSUE:
  - dp_req_valid_o=1, dp_req_data_o=buf[idx]; data must be held stable until ready.
  - On dp_req_ready_i, go to WAIT.
- FSM WAIT:
  - dp_req_valid_o=0.
  - On dp_rsp_valid_i: buf[idx] <= dp_rsp_data_i, idx++.
  - Then, if idx+1==LEN or an abort is pending, go to FIN; else go to ISSUE.
- FSM FIN:
  - DONE=1; ABORTED=abort_pending; clear abort_pending; go to IDLE next cycle.
  - BUSY=1 in ISSUE, WAIT and FIN.
- ABORT:
  - Sets abort_pending.
  - The current word always completes, so exactly one in-flight handshake finishes and no datapath transaction is left dangling. This includes an ISSUE state whose handshake is not yet done.
  - ABORT while IDLE is ignored.
- Datapath: dp_rsp_valid_i outside WAIT is ignored. At most one word is outstanding.
- Buffer write conflicts: datapath writeback and OBI buffer writes cannot collide, because OBI writes are blocked while busy.
- Simultaneous START and CLEAR_DONE in one write: START wins and DONE ends at 0.
- irq_o = DONE & IRQ_EN[0], combinational from registered state.
- Reset mid-operation: returns to IDLE the next cycle and drops dp_req_valid_o. Any later dp_rsp_valid_i is ignored.

Test Plan:
- Write buf[0..2] = 0x00000001, 0x0000000F, 0x12345678; LEN=3; START; bench datapath reverses bits with 2-cycle latency -> buf reads 0x80000000, 0xF0000000, 0x1E6A2C48; STATUS=0x302 (DONE, idx=3).
- IRQ_EN=1, LEN=1, START -> irq_o rises in the FIN+1 cycle; CTRL=0x2 -> irq_o=0 next cycle.
- Hold dp_req_ready_i=0 for 5 cycles during ISSUE -> dp_req_data_o stable, STATUS BUSY=1; buffer write during this time -> err=1, buffer word unchanged.
- LEN=8, START, ABORT while idx=2 in WAIT -> exactly 3 words processed, STATUS=0x306 (DONE, ABORTED, idx=3).
- LEN write 0x1F -> reads back 16; LEN=0, START -> DONE=1 after 1 cycle, dp_req_valid_o never asserted.
- Reads of offset 0x20 and a STATUS write -> rvalid 1 cycle after gnt, err=1, rdata=0, rid echoes aid; back-to-back reads each produce one response.
